proj_trigger_sched: RTL and testbench

Projector trigger scheduler in the CLK_HS domain. Watches the mask-preload STREAM signal and global pixel reset from the CLKMPRE-domain exposure FSM. Fires one fixed-width projector trigger per subscene, timed so the projector settles exactly as mask preload completes. Tracks the pattern index per frame and flags subscenes where the trigger could not be issued in time.

---
 rtl/proj_trigger_sched.sv | 207 ++++++++++++++++++++
 tb/tb_proj_trigger_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/proj_trigger_sched.sv
// proj_trigger_sched
//
// Projector trigger scheduler running in the CLK_HS domain. It watches the
// mask-preload STREAM signal and the global pixel reset coming from the
// CLKMPRE-domain exposure FSM. For each subscene it fires one fixed-width
// projector trigger, timed so the projector settles exactly as the mask
// preload completes. It also tracks the pattern index within a frame and
// flags subscenes whose trigger could not be issued in time.
//
// Optional feature macro: PROJ_SCHED_MISSCNT_EN
//   defined   -> MISS_CNT is a saturating 16-bit late-event counter
//   undefined -> MISS_CNT is tied to zero and no counter is built
//
// Ports:
//   CLK_HS        in   1   fast clock, all logic on posedge
//   RESET         in   1   synchronous, active-high
//   STREAM        in   1   mask preload active (CLKMPRE domain, async)
//   PIXRES_GLOB   in   1   global pixel reset, marks first subscene of frame
//   ENABLE        in   1   arms the scheduler (sampled in IDLE only)
//   PROJ_DELAY    in  32   projector latency in CLK_HS cycles
//   NUM_PAT       in  32   patterns per frame (0 behaves as 1)
//   ERR_CLR       in   1   clears ERR_LATE
//   TRIGGER_PROJ  out  1   projector trigger pulse, C_TRIG_WIDTH cycles
//   PAT_IDX       out 16   index of the current or next pattern
//   TRIG_BUSY     out  1   high whenever the FSM is not in IDLE
//   ERR_LATE      out  1   sticky, STREAM fell before the trigger fired
//   MISS_CNT      out 16   late-event count

module proj_trigger_sched #(
  parameter int C_NUM_ROWS    = 160,
  parameter int C_MASK_DES_L  = 18,
  parameter int C_TRIG_WIDTH  = 4,
  parameter int C_SYNC_STAGES = 2
) (
  input  logic        CLK_HS,
  input  logic        RESET,
  input  logic        STREAM,
  input  logic        PIXRES_GLOB,
  input  logic        ENABLE,
  input  logic [31:0] PROJ_DELAY,
  input  logic [31:0] NUM_PAT,
  input  logic        ERR_CLR,
  output logic        TRIGGER_PROJ,
  output logic [15:0] PAT_IDX,
  output logic        TRIG_BUSY,
  output logic        ERR_LATE,
  output logic [15:0] MISS_CNT
);

  // Total preload length of one subscene in CLK_HS cycles.
  localparam logic [31:0] LOAD     = 32'(C_NUM_ROWS * C_MASK_DES_L);
  localparam logic [31:0] WIDTH_M1 = 32'(C_TRIG_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    ARMED    = 4'b0010,
    FIRE     = 4'b0100,
    WAIT_LOW = 4'b1000
  } state_t;

  state_t state_q, state_d;

  logic [C_SYNC_STAGES-1:0] streamSync_q;
  logic [C_SYNC_STAGES-1:0] pixresSync_q;
  logic streamS;
  logic pixresS;
  logic streamPrev_q;
  logic streamRise_q;
  logic streamFall_q;

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] startVal;
  logic [31:0] numPatEff;
  logic [15:0] patIdx_q, patIdx_d;
  logic [15:0] patNext;
  logic        trig_q, trig_d;
  logic        busy_q, busy_d;
  logic        errLate_q, errLate_d;
  logic        lateEvent;

  // Both CLKMPRE-domain inputs go through plain flop chains; the edge
  // detector behind the STREAM chain is registered so the FSM sees
  // one-cycle rise/fall strobes.
  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      streamSync_q <= '0;
      pixresSync_q <= '0;
      streamPrev_q <= 1'b0;
      streamRise_q <= 1'b0;
      streamFall_q <= 1'b0;
    end else begin
      streamSync_q <= {streamSync_q[C_SYNC_STAGES-2:0], STREAM};
      pixresSync_q <= {pixresSync_q[C_SYNC_STAGES-2:0], PIXRES_GLOB};
      streamPrev_q <= streamS;
      streamRise_q <= streamS & ~streamPrev_q;
      streamFall_q <= ~streamS & streamPrev_q;
    end
  end

  assign streamS = streamSync_q[C_SYNC_STAGES-1];
  assign pixresS = pixresSync_q[C_SYNC_STAGES-1];

  // Countdown start: a projector slower than the whole preload must be
  // triggered immediately, so the subtraction saturates at zero.
  assign startVal  = (PROJ_DELAY >= LOAD) ? 32'd0 : (LOAD - PROJ_DELAY);
  assign numPatEff = (NUM_PAT == 32'd0) ? 32'd1 : NUM_PAT;
  // Compare in 32 bits so large NUM_PAT values let the 16-bit index wrap.
  assign patNext   = ((32'(patIdx_q) + 32'd1) == numPatEff) ? 16'd0
                                                             : patIdx_q + 16'd1;

  // State and output registers.
  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      patIdx_q  <= '0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      errLate_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      patIdx_q  <= patIdx_d;
      trig_q    <= trig_d;
      busy_q    <= busy_d;
      errLate_q <= errLate_d;
    end
  end

  // Next-state logic. cnt is shared: it counts down to the trigger in
  // ARMED and then counts the remaining pulse cycles in FIRE. A cnt==0
  // check ahead of the fall check in ARMED makes a simultaneous fall
  // lose against firing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    patIdx_d  = patIdx_q;
    trig_d    = 1'b0;
    lateEvent = 1'b0;
    case (state_q)
      IDLE: begin
        if (streamRise_q && ENABLE) begin
          state_d = ARMED;
          cnt_d   = startVal;
          if (pixresS) begin
            patIdx_d = '0;
          end
        end
      end
      ARMED: begin
        if (cnt_q == 32'd0) begin
          state_d = FIRE;
          trig_d  = 1'b1;
          cnt_d   = WIDTH_M1;
        end else if (streamFall_q) begin
          lateEvent = 1'b1;
          patIdx_d  = patNext;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      FIRE: begin
        if (cnt_q == 32'd0) begin
          state_d = WAIT_LOW;
        end else begin
          trig_d = 1'b1;
          cnt_d  = cnt_q - 32'd1;
        end
      end
      WAIT_LOW: begin
        if (!streamS) begin
          patIdx_d = patNext;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d    = (state_d != IDLE);
    errLate_d = lateEvent | (errLate_q & ~ERR_CLR);
  end

  assign TRIGGER_PROJ = trig_q;
  assign PAT_IDX      = patIdx_q;
  assign TRIG_BUSY    = busy_q;
  assign ERR_LATE     = errLate_q;

`ifdef PROJ_SCHED_MISSCNT_EN
  logic [15:0] missCnt_q;

  // Saturating late-event counter, cleared only by reset.
  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      missCnt_q <= '0;
    end else if (lateEvent && (missCnt_q != 16'hFFFF)) begin
      missCnt_q <= missCnt_q + 16'd1;
    end
  end

  assign MISS_CNT = missCnt_q;
`else
  assign MISS_CNT = '0;
`endif

endmodule

// File: tb/tb_proj_trigger_sched.sv
// tb_proj_trigger_sched
//
// Directed testbench for proj_trigger_sched with default parameters
// (LOAD = 2880 cycles, 4-cycle trigger, 2-stage synchronizers).

module tb_proj_trigger_sched;

  logic        CLK_HS;
  logic        RESET;
  logic        STREAM;
  logic        PIXRES_GLOB;
  logic        ENABLE;
  logic [31:0] PROJ_DELAY;
  logic [31:0] NUM_PAT;
  logic        ERR_CLR;
  logic        TRIGGER_PROJ;
  logic [15:0] PAT_IDX;
  logic        TRIG_BUSY;
  logic        ERR_LATE;
  logic [15:0] MISS_CNT;

  int compareCount  = 0;
  int mismatchCount = 0;

  int cyc = 0;
  int busyRise = 0;
  int busyFall = 0;
  int trigRise = 0;
  int trigFall = 0;
  int trigCount = 0;
  logic trigPrev = 1'b0;
  logic busyPrev = 1'b0;

  logic [15:0] patDuring;
  int          trigBefore;
  int          expIdx;
`ifdef PROJ_SCHED_MISSCNT_EN
  localparam logic [31:0] EXP_MISS = 32'd1;
`else
  localparam logic [31:0] EXP_MISS = 32'd0;
`endif

  proj_trigger_sched dut (
    .CLK_HS       (CLK_HS),
    .RESET        (RESET),
    .STREAM       (STREAM),
    .PIXRES_GLOB  (PIXRES_GLOB),
    .ENABLE       (ENABLE),
    .PROJ_DELAY   (PROJ_DELAY),
    .NUM_PAT      (NUM_PAT),
    .ERR_CLR      (ERR_CLR),
    .TRIGGER_PROJ (TRIGGER_PROJ),
    .PAT_IDX      (PAT_IDX),
    .TRIG_BUSY    (TRIG_BUSY),
    .ERR_LATE     (ERR_LATE),
    .MISS_CNT     (MISS_CNT)
  );

  // 10 ns clock.
  initial begin
    CLK_HS = 1'b0;
    forever #5 CLK_HS = ~CLK_HS;
  end

  // Edge counter so timing can be measured as edge differences.
  always @(posedge CLK_HS) begin
    cyc <= cyc + 1;
  end

  // Edge monitor: records on which clock edge busy and trigger changed
  // and how many trigger pulses have been seen in total.
  always @(negedge CLK_HS) begin
    trigPrev <= TRIGGER_PROJ;
    busyPrev <= TRIG_BUSY;
    if (TRIGGER_PROJ && !trigPrev) begin
      trigRise  <= cyc;
      trigCount <= trigCount + 1;
    end
    if (!TRIGGER_PROJ && trigPrev) trigFall <= cyc;
    if (TRIG_BUSY && !busyPrev) busyRise <= cyc;
    if (!TRIG_BUSY && busyPrev) busyFall <= cyc;
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one STREAM pulse of the given length, samples PAT_IDX at the
  // end of the high phase, then waits (bounded) for the FSM to go idle.
  task automatic applyStimulus(input int highCycles, input bit pixres,
                               output logic [15:0] patSample);
    @(negedge CLK_HS);
    PIXRES_GLOB = pixres;
    STREAM      = 1'b1;
    repeat (highCycles) @(negedge CLK_HS);
    patSample = PAT_IDX;
    STREAM    = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!TRIG_BUSY) break;
      @(negedge CLK_HS);
    end
    checkOutput("returnIdle", 32'(TRIG_BUSY), 32'd0);
    PIXRES_GLOB = 1'b0;
    repeat (6) @(negedge CLK_HS);
  endtask

  // Main directed sequence.
  initial begin
    RESET       = 1'b1;
    STREAM      = 1'b0;
    PIXRES_GLOB = 1'b0;
    ENABLE      = 1'b1;
    PROJ_DELAY  = 32'd880;
    NUM_PAT     = 32'd8;
    ERR_CLR     = 1'b0;
    repeat (3) @(negedge CLK_HS);
    checkOutput("rstTrig", 32'(TRIGGER_PROJ), 32'd0);
    checkOutput("rstPat", 32'(PAT_IDX), 32'd0);
    checkOutput("rstBusy", 32'(TRIG_BUSY), 32'd0);
    checkOutput("rstErr", 32'(ERR_LATE), 32'd0);
    checkOutput("rstMiss", 32'(MISS_CNT), 32'd0);
    RESET = 1'b0;
    repeat (4) @(negedge CLK_HS);

    // Basic pulse: START = 2000, trigger at E+2001, 4 wide, index 0 -> 1.
    trigBefore = trigCount;
    applyStimulus(3000, 1'b0, patDuring);
    checkOutput("t1Count", 32'(trigCount - trigBefore), 32'd1);
    checkOutput("t1RiseDelay", 32'(trigRise - busyRise), 32'd2001);
    checkOutput("t1Width", 32'(trigFall - trigRise), 32'd4);
    checkOutput("t1PatDuring", 32'(patDuring), 32'd0);
    checkOutput("t1PatAfter", 32'(PAT_IDX), 32'd1);
    checkOutput("t1Err", 32'(ERR_LATE), 32'd0);

    // Pattern cycling, NUM_PAT = 3, short START = 10.
    NUM_PAT    = 32'd3;
    PROJ_DELAY = 32'd2870;
    expIdx     = 1;
    trigBefore = trigCount;
    for (int p = 0; p < 7; p++) begin
      applyStimulus(30, (p == 0), patDuring);
      if (p == 0) expIdx = 0;
      checkOutput($sformatf("t2aPat%0d", p), 32'(patDuring), 32'(expIdx));
      expIdx = (expIdx + 1) % 3;
    end
    checkOutput("t2aCount", 32'(trigCount - trigBefore), 32'd7);
    checkOutput("t2aRiseDelay", 32'(trigRise - busyRise), 32'd11);

    // Same again with the frame marker on the fifth pulse.
    for (int p = 0; p < 7; p++) begin
      applyStimulus(30, (p == 4), patDuring);
      if (p == 4) expIdx = 0;
      checkOutput($sformatf("t2bPat%0d", p), 32'(patDuring), 32'(expIdx));
      expIdx = (expIdx + 1) % 3;
    end
    checkOutput("t2bPatAfter", 32'(PAT_IDX), 32'(expIdx));

    // Projector latency beyond the preload: START saturates to 0.
    PROJ_DELAY = 32'd5000;
    trigBefore = trigCount;
    applyStimulus(30, 1'b0, patDuring);
    expIdx = (expIdx + 1) % 3;
    checkOutput("t3Count", 32'(trigCount - trigBefore), 32'd1);
    checkOutput("t3RiseDelay", 32'(trigRise - busyRise), 32'd1);
    checkOutput("t3Width", 32'(trigFall - trigRise), 32'd4);

    // Late subscene: STREAM falls long before the countdown ends.
    PROJ_DELAY = 32'd0;
    trigBefore = trigCount;
    applyStimulus(1000, 1'b0, patDuring);
    expIdx = (expIdx + 1) % 3;
    checkOutput("t4Count", 32'(trigCount - trigBefore), 32'd0);
    checkOutput("t4Err", 32'(ERR_LATE), 32'd1);
    checkOutput("t4Pat", 32'(PAT_IDX), 32'(expIdx));
    checkOutput("t4Miss", 32'(MISS_CNT), EXP_MISS);
    @(negedge CLK_HS);
    ERR_CLR = 1'b1;
    @(negedge CLK_HS);
    ERR_CLR = 1'b0;
    checkOutput("t4ErrClr", 32'(ERR_LATE), 32'd0);
    checkOutput("t4MissKept", 32'(MISS_CNT), EXP_MISS);

    // STREAM falls in the second FIRE cycle: full pulse, then idle next edge.
    PROJ_DELAY = 32'd2870;
    trigBefore = trigCount;
    applyStimulus(14, 1'b0, patDuring);
    expIdx = (expIdx + 1) % 3;
    checkOutput("t5Count", 32'(trigCount - trigBefore), 32'd1);
    checkOutput("t5Width", 32'(trigFall - trigRise), 32'd4);
    checkOutput("t5IdleAfter", 32'(busyFall - trigFall), 32'd1);
    checkOutput("t5Pat", 32'(PAT_IDX), 32'(expIdx));

    // Reset in the middle of FIRE, then a normal pulse afterwards.
    @(negedge CLK_HS);
    STREAM = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (TRIGGER_PROJ) break;
      @(negedge CLK_HS);
    end
    checkOutput("t6FireReached", 32'(TRIGGER_PROJ), 32'd1);
    @(negedge CLK_HS);
    RESET  = 1'b1;
    STREAM = 1'b0;
    @(negedge CLK_HS);
    checkOutput("t6RstTrig", 32'(TRIGGER_PROJ), 32'd0);
    checkOutput("t6RstPat", 32'(PAT_IDX), 32'd0);
    checkOutput("t6RstBusy", 32'(TRIG_BUSY), 32'd0);
    checkOutput("t6RstErr", 32'(ERR_LATE), 32'd0);
    checkOutput("t6RstMiss", 32'(MISS_CNT), 32'd0);
    repeat (2) @(negedge CLK_HS);
    RESET = 1'b0;
    repeat (5) @(negedge CLK_HS);
    trigBefore = trigCount;
    applyStimulus(30, 1'b0, patDuring);
    checkOutput("t6Count", 32'(trigCount - trigBefore), 32'd1);
    checkOutput("t6RiseDelay", 32'(trigRise - busyRise), 32'd11);
    checkOutput("t6Width", 32'(trigFall - trigRise), 32'd4);
    checkOutput("t6Pat", 32'(PAT_IDX), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
